// File: rtl/led_palette_pwm_driver.sv
// led_palette_pwm_driver
// Turns the 8-bit palette values for the RGB and basic LEDs into PWM drive.
// Palette values are double-buffered: they go into shadow registers only on
// a period boundary, so a change in mid-period never distorts a period.
module led_palette_pwm_driver #(
    parameter int parm_color_led_count = 4,
    parameter int parm_basic_led_count = 4,
    parameter int parm_FCLK            = 40_000_000,
    parameter int parm_pwm_frequency   = 500
) (
    input  logic                              i_clk,
    input  logic                              i_srst,
    input  logic [8*parm_color_led_count-1:0] i_color_led_red_value,
    input  logic [8*parm_color_led_count-1:0] i_color_led_green_value,
    input  logic [8*parm_color_led_count-1:0] i_color_led_blue_value,
    input  logic [8*parm_basic_led_count-1:0] i_basic_led_lumin_value,
    output logic [parm_color_led_count-1:0]   o_color_led_red,
    output logic [parm_color_led_count-1:0]   o_color_led_green,
    output logic [parm_color_led_count-1:0]   o_color_led_blue,
    output logic [parm_basic_led_count-1:0]   o_basic_led,
    output logic                              o_period_start
);

    // Clocks per duty step. A period holds 255 steps (duty 0..254), so a
    // value of 255 compares above every duty count and stays lit throughout.
    localparam int c_step_divisor = parm_FCLK / (parm_pwm_frequency * 255);
    localparam int c_step_w       = (c_step_divisor > 1) ? $clog2(c_step_divisor) : 1;

    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(c_step_divisor - 1);
    localparam logic [7:0]          c_duty_last = 8'd254;

    localparam int c_cw = 8 * parm_color_led_count;
    localparam int c_bw = 8 * parm_basic_led_count;

    logic [c_step_w-1:0] step_cnt, step_next;
    logic [7:0]          duty_cnt, duty_next;
    logic                s_step_ce;
    logic                load_pending;
    logic                load_cycle;

    logic [c_cw-1:0] red_shadow,   red_shadow_next;
    logic [c_cw-1:0] green_shadow, green_shadow_next;
    logic [c_cw-1:0] blue_shadow,  blue_shadow_next;
    logic [c_bw-1:0] basic_shadow, basic_shadow_next;

    logic [parm_color_led_count-1:0] red_next, green_next, blue_next;
    logic [parm_basic_led_count-1:0] basic_next;

    // Counter, load and shadow next-state: the values every register takes at the next edge.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        s_step_ce  = (step_cnt == c_step_last);
        load_cycle = load_pending | (s_step_ce & (duty_cnt == c_duty_last));

        step_next = s_step_ce ? '0 : step_cnt + 1'b1;
        duty_next = duty_cnt;
        if (s_step_ce) begin
            duty_next = (duty_cnt == c_duty_last) ? 8'd0 : duty_cnt + 8'd1;
        end

        // The first period after reset starts from a clean count, so it runs the full length like every other period.
        if (load_pending) begin
            step_next = '0;
            duty_next = 8'd0;
        end

        red_shadow_next   = red_shadow;
        green_shadow_next = green_shadow;
        blue_shadow_next  = blue_shadow;
        basic_shadow_next = basic_shadow;
        if (load_cycle) begin
            red_shadow_next   = i_color_led_red_value;
            green_shadow_next = i_color_led_green_value;
            blue_shadow_next  = i_color_led_blue_value;
            basic_shadow_next = i_basic_led_lumin_value;
        end
    end

    // Per-channel compare against the next duty count, so the registered output lines up with the counter.
    always_comb begin
        red_next   = '0;
        green_next = '0;
        blue_next  = '0;
        basic_next = '0;
        for (int n = 0; n < parm_color_led_count; n++) begin
            red_next[n]   = (duty_next < red_shadow_next[8*n +: 8]);
            green_next[n] = (duty_next < green_shadow_next[8*n +: 8]);
            blue_next[n]  = (duty_next < blue_shadow_next[8*n +: 8]);
        end
        for (int n = 0; n < parm_basic_led_count; n++) begin
            basic_next[n] = (duty_next < basic_shadow_next[8*n +: 8]);
        end
    end

    // State register: counters, load flag, shadows and the registered LED drives.
    always_ff @(posedge i_clk) begin
        // NOTE: state updates use non-blocking assignments so every register samples the pre-edge values.
        if (i_srst) begin
            // NOTE: the shadows are a handful of flops rather than a RAM, so clearing them in reset is cheap and keeps the outputs dark.
            step_cnt          <= '0;
            duty_cnt          <= 8'd0;
            load_pending      <= 1'b1;
            red_shadow        <= '0;
            green_shadow      <= '0;
            blue_shadow       <= '0;
            basic_shadow      <= '0;
            o_color_led_red   <= '0;
            o_color_led_green <= '0;
            o_color_led_blue  <= '0;
            o_basic_led       <= '0;
            o_period_start    <= 1'b0;
        end else begin
            step_cnt          <= step_next;
            duty_cnt          <= duty_next;
            load_pending      <= 1'b0;
            red_shadow        <= red_shadow_next;
            green_shadow      <= green_shadow_next;
            blue_shadow       <= blue_shadow_next;
            basic_shadow      <= basic_shadow_next;
            o_color_led_red   <= red_next;
            o_color_led_green <= green_next;
            o_color_led_blue  <= blue_next;
            o_basic_led       <= basic_next;
            o_period_start    <= load_cycle;
        end
    end

endmodule

// File: tb/tb_led_palette_pwm_driver.sv
// Bench for led_palette_pwm_driver with a 4-clock duty step (1020-clock period).
// The driver pushes the expected lit-clock counts of each period as that
// period starts; the monitor measures every completed period and compares.
module tb_led_palette_pwm_driver;

    localparam int c_period = 1020;

    typedef struct packed {
        logic [10:0]       len;
        logic [15:0][10:0] lit;   // red0..3, green0..3, blue0..3, basic0..3
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_srst;
    logic [31:0] red_v, green_v, blue_v, basic_v;
    logic [3:0]  o_color_led_red, o_color_led_green, o_color_led_blue, o_basic_led;
    logic        o_period_start;
    logic [15:0] all_out;

    int   n_vectors     = 0;
    int   n_miscompares = 0;
    exp_t exp_q[$];
    exp_t cur;

    // Monitor state for the period being measured.
    bit in_period = 1'b0;
    int mon_len;
    int mon_lit[16];
    bit mon_low[16];
    int mon_brk;
    int pidx = 1;

    led_palette_pwm_driver #(
        .parm_color_led_count(4),
        .parm_basic_led_count(4),
        .parm_FCLK(1020),
        .parm_pwm_frequency(1)
    ) dut (
        .i_clk(i_clk),
        .i_srst(i_srst),
        .i_color_led_red_value(red_v),
        .i_color_led_green_value(green_v),
        .i_color_led_blue_value(blue_v),
        .i_basic_led_lumin_value(basic_v),
        .o_color_led_red(o_color_led_red),
        .o_color_led_green(o_color_led_green),
        .o_color_led_blue(o_color_led_blue),
        .o_basic_led(o_basic_led),
        .o_period_start(o_period_start)
    );

    assign all_out = {o_basic_led, o_color_led_blue, o_color_led_green, o_color_led_red};

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int actual, input int expected);
        n_vectors++;
        if (actual != expected) begin
            n_miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Waits for the next period-start pulse (bounded) and optionally queues the period's expectation.
    task automatic wait_period_start(input string tag, input bit push);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < c_period + 50) begin
            @(posedge i_clk);
            #1;
            n++;
            seen = o_period_start;
        end
        check({tag, " period start"}, int'(seen), 1);
        if (push) exp_q.push_back(cur);
    endtask

    task automatic finish_period();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vectors++;
            n_miscompares++;
            $display("FAIL p%0d: period completed with no expected entry", pidx);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("p%0d len", pidx), mon_len, int'(e.len));
            for (int ch = 0; ch < 16; ch++) begin
                check($sformatf("p%0d ch%0d lit", pidx, ch), mon_lit[ch], int'(e.lit[ch]));
            end
            check($sformatf("p%0d contiguous", pidx), mon_brk, 0);
        end
        pidx++;
    endtask

    // Monitor: measures each period between period-start pulses; a reset aborts the period in progress.
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_srst) begin
                in_period = 1'b0;
            end else begin
                if (o_period_start) begin
                    if (in_period) finish_period();
                    in_period = 1'b1;
                    mon_len   = 0;
                    mon_brk   = 0;
                    for (int ch = 0; ch < 16; ch++) begin
                        mon_lit[ch] = 0;
                        mon_low[ch] = 1'b0;
                    end
                end
                if (in_period) begin
                    mon_len++;
                    for (int ch = 0; ch < 16; ch++) begin
                        if (all_out[ch]) begin
                            mon_lit[ch]++;
                            if (mon_low[ch]) mon_brk++;
                        end else begin
                            mon_low[ch] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Driver: directed palette changes timed from the period-start pulses.
    initial begin
        i_srst  = 1'b1;
        red_v   = 32'h0000_FF40;   // red1=FF, red0=40
        green_v = 32'h0000_0000;
        blue_v  = 32'h2000_0000;   // blue3=20
        basic_v = 32'h0010_0000;   // basic2=10
        cur     = '0;
        cur.len     = 11'd1020;
        cur.lit[0]  = 11'd256;     // 0x40 * 4
        cur.lit[1]  = 11'd1020;
        cur.lit[11] = 11'd128;     // 0x20 * 4
        cur.lit[14] = 11'd64;      // 0x10 * 4

        clocks(4);
        check("reset outputs", int'({all_out, o_period_start}), 0);
        i_srst = 1'b0;
        clocks(1);
        check("first period start after release", int'(o_period_start), 1);
        exp_q.push_back(cur);                           // P1

        wait_period_start("p2", 1'b1);
        clocks(100);
        basic_v[23:16] = 8'h80;                         // mid-period: takes effect in P3
        cur.lit[14] = 11'd512;

        wait_period_start("p3", 1'b1);
        clocks(c_period - 1);                           // now inside the load cycle
        blue_v[31:24] = 8'h60;
        cur.lit[11] = 11'd384;

        wait_period_start("p4", 1'b1);
        clocks(10);
        red_v[7:0] = 8'hFF;
        cur.lit[0] = 11'd1020;

        wait_period_start("p5", 1'b0);                  // this period is cut short by reset
        clocks(500);
        i_srst = 1'b1;
        clocks(1);
        check("mid-period reset outputs", int'({all_out, o_period_start}), 0);
        i_srst = 1'b0;
        clocks(1);
        check("period start after reset", int'(o_period_start), 1);
        check("red0 lit after reset", int'(o_color_led_red[0]), 1);
        exp_q.push_back(cur);                           // P6

        clocks(10);
        red_v[7:0] = 8'h00;
        cur.lit[0] = 11'd0;
        wait_period_start("p7", 1'b1);
        clocks(10);
        red_v[7:0] = 8'h01;
        cur.lit[0] = 11'd4;
        wait_period_start("p8", 1'b1);
        clocks(10);
        red_v[7:0] = 8'h7F;
        cur.lit[0] = 11'd508;
        wait_period_start("p9", 1'b1);
        clocks(10);
        red_v[7:0] = 8'hFE;
        cur.lit[0] = 11'd1016;
        wait_period_start("p10", 1'b1);
        clocks(10);
        red_v[7:0] = 8'hFF;
        cur.lit[0] = 11'd1020;
        wait_period_start("p11", 1'b1);

        wait_period_start("p12", 1'b0);
        @(negedge i_clk);
        #1;
        check("expectations drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    // Hard stop in case the run stalls.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_palette_pwm_driver.md
Name: led_palette_pwm_driver

Overview:
- Receiver for the LED palette buses produced by the palette pulser.
- Converts each 8-bit per-channel palette value into a glitch-free PWM drive for the RGB color LEDs and the basic (single-color) LEDs.
- Double-buffers all palette values and applies them only at PWM period boundaries, so a mid-period palette change never distorts a period.
- Sits between the palette generator and the board LED pins.

Parameters:
- parm_color_led_count, 4, number of RGB LEDs.
- parm_basic_led_count, 4, number of basic LEDs.
- parm_FCLK, 40_000_000, i_clk frequency in Hz.
- parm_pwm_frequency, 500, PWM periods per second.
- c_step_divisor, parm_FCLK / (parm_pwm_frequency * 255), integer-truncated; clocks per duty step; must be >= 1.

Ports:
- i_clk  in  1  system clock
- i_srst  in  1  synchronous reset, active-high
- i_color_led_red_value  in  8*parm_color_led_count  red duty per LED; LED n at bits [8n+7:8n]
- i_color_led_green_value  in  8*parm_color_led_count  green duty, same packing
- i_color_led_blue_value  in  8*parm_color_led_count  blue duty, same packing
- i_basic_led_lumin_value  in  8*parm_basic_led_count  basic LED duty, same packing
- o_color_led_red  out  parm_color_led_count  red PWM drive, 1 = lit
- o_color_led_green  out  parm_color_led_count  green PWM drive
- o_color_led_blue  out  parm_color_led_count  blue PWM drive
- o_basic_led  out  parm_basic_led_count  basic LED PWM drive
- o_period_start  out  1  one-clock pulse on each shadow-load cycle

Behaviour:
- Interface: one clock, i_clk. Reset i_srst is synchronous and active-high. No other clock or reset domains.
- Step counter: 0..c_step_divisor-1, increments every clock and wraps to 0. s_step_ce is asserted combinationally when the counter equals c_step_divisor-1.
- Duty counter:
  - 8 bits, 0..254, advances by 1 on each s_step_ce.
  - On s_step_ce at 254 it wraps to 0; it never holds 255.
  - Period length = 255*c_step_divisor clocks.
- Load pending flag:
  - Set by reset.
  - Load cycle = (load pending) OR (s_step_ce AND duty==254).
  - The flag clears on the load cycle.
- Shadow registers:
  - On a load cycle, all input values are captured into per-channel shadow registers.
  - Shadows hold until the next load cycle.
  - Inputs changing on the load cycle itself are captured as sampled at that clock edge.
- o_period_start: registered, high for exactly one clock, the clock after each load cycle.
- Channel output:
  - Registered: out <= (duty_next < shadow_next), where duty_next and shadow_next are the values the counter and shadow take at the same edge.
  - Output therefore aligns with the duty count with zero extra lag beyond the register.
  - Value 0 is never lit. Value 255 is lit for the full period with no one-step gap. Value v is lit for v*c_step_divisor clocks per period, starting at the period start.
- Reset (any time, including mid-period):
  - Next clock: all outputs 0, o_period_start 0, counters 0, shadows 0, load pending 1.
  - First clock after i_srst deasserts is a load cycle; the PWM restarts at duty 0.
- Channels are independent. No cross-channel phase offset; all channels rise together at the period start.
- Width rules:
  - Comparison is unsigned 8-bit.
  - Step-counter width = $clog2(c_step_divisor) bits, minimum 1.

Test Plan:
- Common setup: parm_FCLK=1020, parm_pwm_frequency=1 → c_step_divisor=4, period 1020 clocks.
- Release reset with red0=0x40, others 0x00 → o_period_start pulses on clock 1 after release and every 1020 clocks after; o_color_led_red[0] high for 256 consecutive clocks then low for 764 per period; all other outputs stay 0.
- red1=0xFF, green1=0x00 → o_color_led_red[1] constantly 1 across ≥3 periods, including boundaries; o_color_led_green[1] constantly 0.
- Change basic2 from 0x10 to 0x80 mid-period at clock 100 of the period → that period shows 64 lit clocks; the following period shows 512 lit clocks.
- Change blue3 0x20→0x60 on exactly the load cycle → the new period shows 384 lit clocks, with no 128-clock period in between.
- Assert i_srst for 1 clock at mid-period while red0=0xFF → all outputs 0 the next clock; one clock after release o_period_start=1 and red0 lit again; next o_period_start 1020 clocks later.
- Sweep red0 through 0x00, 0x01, 0x7F, 0xFE, 0xFF → lit clocks per period are 0, 4, 508, 1016, and 1020 (continuous), respectively.
